// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the CPU read port.
// Provides head data, fill count, sticky overflow and registered RTS flow control.
module uart_rx_fifo #(
  parameter int DEPTH     = 4,
  parameter int RTS_LEVEL = 3
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       rx_strobe,
  input  logic [7:0]                 rx_data,
  input  logic                       pop,
  input  logic                       flush,
  input  logic                       clear_ovf,
  output logic [7:0]                 rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  output logic                       rts
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] RTS_C   = CW'(RTS_LEVEL);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          do_push;
  logic          do_pop;
  logic          ovf_event;
  logic [CW-1:0] count_next;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign rd_valid = !empty;
  assign rd_data  = empty ? 8'h00 : mem[rd_ptr];

  // At full, a coincident pop frees the slot the push needs, so nothing is dropped.
  always_comb begin
    do_push    = 1'b0;
    do_pop     = 1'b0;
    ovf_event  = 1'b0;
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      do_pop    = pop && !empty;
      do_push   = rx_strobe && (!full || do_pop);
      ovf_event = rx_strobe && full && !do_pop;
      count_next = count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rts      <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      rts   <= (count_next >= RTS_C);
      if (ovf_event)      overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed steps plus randomized traffic
// compared against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH     = 4;
  localparam int RTS_LEVEL = 3;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rx_strobe = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          pop = 1'b0;
  logic          flush = 1'b0;
  logic          clear_ovf = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
  logic          rts;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q[$];
  logic       m_ovf = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH), .RTS_LEVEL(RTS_LEVEL)) dut (
    .clk(clk), .rstn(rstn), .rx_strobe(rx_strobe), .rx_data(rx_data),
    .pop(pop), .flush(flush), .clear_ovf(clear_ovf), .rd_data(rd_data),
    .rd_valid(rd_valid), .count(count), .full(full), .overflow(overflow), .rts(rts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] head;
    head = (q.size() > 0) ? q[0] : 8'h00;
    chk({tag, ".rd_data"},  rd_data, head);
    chk({tag, ".rd_valid"}, {7'b0, rd_valid}, {7'b0, q.size() > 0});
    chk({tag, ".count"},    8'(count), 8'(q.size()));
    chk({tag, ".full"},     {7'b0, full}, {7'b0, q.size() == DEPTH});
    chk({tag, ".overflow"}, {7'b0, overflow}, {7'b0, m_ovf});
    chk({tag, ".rts"},      {7'b0, rts}, {7'b0, q.size() >= RTS_LEVEL});
  endtask

  // One clock of stimulus; the model applies the behavioural rules directly.
  task automatic step(input logic s, input logic [7:0] d, input logic p,
                      input logic f, input logic c, input string tag);
    int  sz;
    logic popped, ovf_ev;
    @(negedge clk);
    rx_strobe = s; rx_data = d; pop = p; flush = f; clear_ovf = c;
    @(posedge clk);
    #1;
    rx_strobe = 1'b0; pop = 1'b0; flush = 1'b0; clear_ovf = 1'b0;
    sz = q.size();
    ovf_ev = 1'b0;
    if (f) begin
      q.delete();
    end else begin
      popped = p && sz > 0;
      if (popped) void'(q.pop_front());
      if (s && (sz < DEPTH || popped)) q.push_back(d);
      ovf_ev = s && sz == DEPTH && !popped;
    end
    if (ovf_ev) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    check_model(tag);
  endtask

  initial begin
    #12;
    chk("reset.rd_data", rd_data, 8'h00);
    chk("reset.count", 8'(count), 8'h00);
    chk("reset.full", {7'b0, full}, 8'h00);
    @(negedge clk);
    rstn = 1'b1;

    // basic push/pop
    step(1, 8'h41, 0, 0, 0, "p41");
    step(1, 8'h42, 0, 0, 0, "p42");
    chk("basic.head", rd_data, 8'h41);
    step(0, 8'h00, 1, 0, 0, "pop1");
    chk("basic.second", rd_data, 8'h42);
    step(0, 8'h00, 1, 0, 0, "pop2");
    chk("basic.empty", rd_data, 8'h00);

    // fill, rts threshold, overflow, drain in order
    for (int i = 0; i < 4; i++) step(1, 8'h10 + 8'(i), 0, 0, 0, "fill");
    chk("fill.full", {7'b0, full}, 8'h01);
    step(1, 8'h14, 0, 0, 0, "drop");
    chk("drop.ovf", {7'b0, overflow}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      chk("drain.order", rd_data, 8'h10 + 8'(i));
      step(0, 8'h00, 1, 0, 0, "drain");
    end

    // full with coincident push and pop
    step(0, 8'h00, 0, 0, 1, "clr");
    for (int i = 0; i < 4; i++) step(1, 8'h20 + 8'(i), 0, 0, 0, "refill");
    step(1, 8'h55, 1, 0, 0, "fullpp");
    chk("fullpp.ovf", {7'b0, overflow}, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0, "pp_drain");
    chk("fullpp.last", rd_data, 8'h55);
    step(0, 8'h00, 1, 0, 0, "pp_last");

    // empty with coincident push and pop, then clear vs set
    step(1, 8'h77, 1, 0, 0, "emptypp");
    chk("emptypp.head", rd_data, 8'h77);
    for (int i = 0; i < 3; i++) step(1, 8'h30 + 8'(i), 0, 0, 0, "fill2");
    step(1, 8'h3f, 0, 0, 1, "setwins");
    chk("setwins.ovf", {7'b0, overflow}, 8'h01);

    // flush beats push
    step(0, 8'h00, 0, 1, 0, "flush0");
    for (int i = 0; i < 3; i++) step(1, 8'h60 + 8'(i), 0, 0, 0, "fill3");
    step(1, 8'h99, 0, 1, 0, "flush99");
    chk("flush.count", 8'(count), 8'h00);
    chk("flush.rts", {7'b0, rts}, 8'h00);

    // pointer wrap
    for (int i = 0; i < 10; i++) begin
      step(1, 8'hA0 + 8'(i), 0, 0, 0, "wrap_push");
      chk("wrap.data", rd_data, 8'hA0 + 8'(i));
      step(0, 8'h00, 1, 0, 0, "wrap_pop");
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0), "rand");
    end

    // async reset mid-stream with count=2, overflow=1
    step(0, 8'h00, 0, 1, 1, "pre_rst");
    for (int i = 0; i < 5; i++) step(1, 8'hC0 + 8'(i), 0, 0, 0, "rst_fill");
    step(0, 8'h00, 1, 0, 0, "rst_pop");
    step(0, 8'h00, 1, 0, 0, "rst_pop");
    chk("prerst.count", 8'(count), 8'h02);
    chk("prerst.ovf", {7'b0, overflow}, 8'h01);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst.count", 8'(count), 8'h00);
    chk("arst.ovf", {7'b0, overflow}, 8'h00);
    chk("arst.rts", {7'b0, rts}, 8'h00);
    chk("arst.rd_data", rd_data, 8'h00);
    chk("arst.rd_valid", {7'b0, rd_valid}, 8'h00);
    q.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step(1, 8'h5a, 0, 0, 0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer between the UART byte receiver and the CPU peripheral read port. It captures each received byte into a small FIFO so several bytes can arrive while software is busy. It generates the RTS flow-control output from the fill level. It presents head data, status, count and a sticky overflow flag to the peripheral read mux and the interrupt logic.

Parameters:
DEPTH, 4, number of byte entries; power of two, minimum 2
RTS_LEVEL, 3, fill count at or above which rts asserts; range 1..DEPTH

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
rx_strobe  input  1  single-cycle pulse from receiver: rx_data holds a new byte
rx_data  input  8  received byte, valid when rx_strobe=1
pop  input  1  single-cycle pulse: CPU completed read of data register (read_complete & address match)
flush  input  1  single-cycle pulse: discard all contents
clear_ovf  input  1  single-cycle pulse: clear sticky overflow flag
rd_data  output  8  head byte; 8'h00 when empty
rd_valid  output  1  FIFO non-empty; also used as the RX interrupt request
count  output  $clog2(DEPTH)+1  current number of stored bytes
full  output  1  count == DEPTH
overflow  output  1  sticky: a byte was dropped because the FIFO was full
rts  output  1  1 = ask remote sender to pause

Behaviour:
- Reset: rstn low asynchronously clears wr_ptr, rd_ptr, count, overflow and rts to 0. Memory contents are not reset. Outputs during reset: rd_valid=0, rd_data=8'h00, full=0.
- Storage: DEPTH x 8 registers. wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. count is a separate register of width $clog2(DEPTH)+1.
- Push: rx_strobe=1 with count<DEPTH writes rx_data at wr_ptr, then wr_ptr+1.
- Pop: pop=1 with count>0 advances rd_ptr by 1.
- Latency: a pushed byte is visible on rd_data/rd_valid the cycle after the strobe. After a pop, the next head byte is visible the cycle after the pop.
- rd_data = mem[rd_ptr] when count>0, else 8'h00 (combinational from registered state).
- Simultaneous push and pop, count between 1 and DEPTH-1: both occur and count is unchanged.
- Simultaneous push and pop, count==DEPTH: both occur, no overflow, count stays DEPTH.
- Simultaneous push and pop, count==0: push occurs, pop is ignored, count becomes 1.
- Push while full without pop: byte dropped; pointers and count unchanged; overflow set to 1 next cycle.
- Pop while empty: ignored; no state change.
- overflow is sticky until clear_ovf or reset. If clear_ovf and a new overflow event occur in the same cycle, overflow stays 1 (set wins).
- flush: the next cycle has wr_ptr=rd_ptr=0 and count=0. flush has priority over push and pop in the same cycle; a coincident byte is discarded. flush does not set overflow and does not alter it.
- rts: registered, updated in the same edge as count. rts = (count_next >= RTS_LEVEL). It therefore changes on the same cycle count crosses the level, with no hysteresis.
- full = (count == DEPTH), combinational from count.
- No other state and no FSM beyond pointer/count bookkeeping. Everything is synchronous to clk except the asynchronous reset.

Test Plan:
- Reset, then rx_strobe with 0x41, 0x42 on separate cycles -> count=2, rd_valid=1, rd_data=0x41. Pop -> next cycle rd_data=0x42, count=1. Pop -> rd_data=0x00, rd_valid=0.
- DEPTH=4, RTS_LEVEL=3, push 0x10..0x13 -> rts rises on the cycle count becomes 3, full=1 at count 4. Push 0x14 -> byte dropped, overflow=1, count=4. Pop four times -> 0x10,0x11,0x12,0x13 in order, and rts falls when count becomes 2.
- Full FIFO, rx_strobe 0x55 with pop in the same cycle -> overflow stays 0, count=4, 0x55 emerges last after popping the existing three.
- Empty FIFO, rx_strobe 0x77 with pop in the same cycle -> count=1, rd_data=0x77. Then clear_ovf with a coincident overflow-causing push at full -> overflow remains 1.
- Fill to 3 with push 0x99 coincident with flush -> count=0, rd_valid=0, rts=0. Then wrap test: 10 push/pop pairs across pointer wrap return data in order.
- Assert rstn low mid-stream with count=2 and overflow=1 -> immediately count=0, overflow=0, rts=0, rd_data=0x00, without waiting for a clk edge.
